// File: rtl/oil_slick_controller_pkg.sv
// Shared constants, state type and lane helper for the oil-slick sprite controller.
package hp_pkg;

  localparam int SPR_W     = 48;
  localparam int SPR_H     = 36;
  localparam int ROAD_LEFT = 160;
  localparam int LANE_W    = 112;
  localparam int CAR_W     = 32;
  localparam int CAR_H     = 48;
  localparam int SCREEN_H  = 480;

  localparam logic [7:0] LFSR_SEED = 8'hA5;
  localparam logic [7:0] LFSR_TAPS = 8'hB8;
  localparam logic [7:0] CD_RESET  = 8'd64;
  localparam logic [7:0] CD_BASE   = 8'd32;

  typedef enum logic [1:0] {IDLE, ACTIVE, HIT} oil_state_t;

  // Lane 3 does not exist on the road and folds onto lane 0.
  function automatic logic [9:0] lane_x(input logic [1:0] sel);
    logic [1:0] lane;
    lane = (sel == 2'd3) ? 2'd0 : sel;
    return 10'(ROAD_LEFT + (LANE_W - SPR_W) / 2) + 10'(lane) * 10'(LANE_W);
  endfunction

endpackage

// File: rtl/oil_slick_controller_if.sv
// Frame, pixel, car and sprite-ROM signals of the oil-slick controller.
interface oil_slick_controller_if;

  logic                frame_clk;
  logic [9:0]          DrawX;
  logic [9:0]          DrawY;
  logic [3:0]          scroll_speed;
  logic [9:0]          car_x;
  logic [9:0]          car_y;
  logic [11:0]         read_address;
  logic                oil_on;
  logic [9:0]          oil_x;
  logic signed [10:0]  oil_y;
  logic                hit;

  modport master (
    output frame_clk, DrawX, DrawY, scroll_speed, car_x, car_y,
    input  read_address, oil_on, oil_x, oil_y, hit
  );

  modport slave (
    input  frame_clk, DrawX, DrawY, scroll_speed, car_x, car_y,
    output read_address, oil_on, oil_x, oil_y, hit
  );

endinterface

// File: rtl/oil_slick_controller_lfsr.sv
// 8-bit Galois LFSR (x^8+x^6+x^5+x^4+1) that advances only when enabled.
module hp_lfsr8
  import hp_pkg::*;
(
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       en_i,
  output logic [7:0] q_o
);

  logic [7:0] q_q;
  logic [7:0] q_d;

  always_comb begin
    q_d = q_q;
    if (en_i) begin
      q_d = {1'b0, q_q[7:1]} ^ (q_q[0] ? LFSR_TAPS : '0);
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      q_q <= LFSR_SEED;
    end else begin
      q_q <= q_d;
    end
  end

  assign q_o = q_q;

endmodule

// File: rtl/oil_slick_controller.sv
// Oil-slick spawner/scroller with car collision and a 2-stage sprite ROM address pipe.
module oil_slick_controller
  import hp_pkg::*;
(
  input logic                   Clk,
  input logic                   Reset,
  oil_slick_controller_if.slave bus
);

  localparam logic signed [11:0] S_SPR_W    = 12'(SPR_W);
  localparam logic signed [11:0] S_SPR_H    = 12'(SPR_H);
  localparam logic signed [11:0] S_CAR_W    = 12'(CAR_W);
  localparam logic signed [11:0] S_CAR_H    = 12'(CAR_H);
  localparam logic signed [11:0] S_SCREEN_H = 12'(SCREEN_H);
  localparam logic signed [10:0] OY_START   = 11'(-SPR_H);

  logic [2:0]         sync_q;
  logic               tick;
  oil_state_t         state_q, state_d;
  logic [7:0]         cnt_q, cnt_d;
  logic [9:0]         ox_q, ox_d;
  logic signed [10:0] oy_q, oy_d;
  logic               hit_q, hit_d;
  logic [7:0]         lfsr;
  logic               lfsr_unused;
  logic signed [11:0] ny, cx, cy, oxs, dx, dy;
  logic               exit_w, ovl, in_box;
  logic [11:0]        addr_q, addr_d;
  logic               on1_q, on2_q;

  // sync_q[1:0] is the two-flop synchroniser, sync_q[2] the edge-detect history.
  assign tick = sync_q[1] & ~sync_q[2];

  hp_lfsr8 u_lfsr (
    .clk_i (Clk),
    .rst_i (Reset),
    .en_i  (tick),
    .q_o   (lfsr)
  );

  assign lfsr_unused = lfsr[7];

  assign ny     = {oy_q[10], oy_q} + {8'b0, bus.scroll_speed};
  assign cx     = {2'b00, bus.car_x};
  assign cy     = {2'b00, bus.car_y};
  assign oxs    = {2'b00, ox_q};
  assign exit_w = (ny >= S_SCREEN_H);
  assign ovl    = (cx < oxs + S_SPR_W) && (oxs < cx + S_CAR_W) &&
                  (cy < ny + S_SPR_H)  && (ny < cy + S_CAR_H);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    ox_d    = ox_q;
    oy_d    = oy_q;
    hit_d   = 1'b0;
    if (tick) begin
      unique case (state_q)
        IDLE: begin
          if (cnt_q == 8'd1) begin
            state_d = ACTIVE;
            ox_d    = lane_x(lfsr[1:0]);
            oy_d    = OY_START;
            cnt_d   = CD_BASE + {1'b0, lfsr[6:0]};
          end else begin
            cnt_d = cnt_q - 8'd1;
          end
        end
        ACTIVE: begin
          oy_d = ny[10:0];
          // Leaving the screen takes priority over a collision on the same tick.
          if (exit_w) begin
            state_d = IDLE;
          end else if (ovl) begin
            hit_d   = 1'b1;
            state_d = HIT;
          end
        end
        HIT: begin
          oy_d = ny[10:0];
          if (exit_w) begin
            state_d = IDLE;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  assign dx     = {2'b00, bus.DrawX} - oxs;
  assign dy     = {2'b00, bus.DrawY} - {oy_q[10], oy_q};
  assign in_box = (state_q != IDLE) && !dx[11] && (dx < S_SPR_W) && !dy[11] && (dy < S_SPR_H);
  assign addr_d = in_box ? ((dy << 5) + (dy << 4) + dx) : '0;

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      sync_q  <= '0;
      state_q <= IDLE;
      cnt_q   <= CD_RESET;
      ox_q    <= '0;
      oy_q    <= OY_START;
      hit_q   <= 1'b0;
    end else begin
      sync_q  <= {sync_q[1:0], bus.frame_clk};
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ox_q    <= ox_d;
      oy_q    <= oy_d;
      hit_q   <= hit_d;
    end
  end

  // oil_on carries an extra stage so it lines up with the ROM's registered data_out.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      addr_q <= '0;
      on1_q  <= 1'b0;
      on2_q  <= 1'b0;
    end else begin
      addr_q <= addr_d;
      on1_q  <= in_box;
      on2_q  <= on1_q;
    end
  end

  assign bus.read_address = addr_q;
  assign bus.oil_on       = on2_q;
  assign bus.oil_x        = ox_q;
  assign bus.oil_y        = oy_q;
  assign bus.hit          = hit_q;

endmodule

// File: tb/tb_oil_slick_controller.sv
// Bench for oil_slick_controller: directed sequences, an address table and a randomized run against a reference model.
module tb_oil_slick_controller;
  import hp_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  oil_slick_controller_if bus ();

  oil_slick_controller dut (
    .Clk   (clk),
    .Reset (rst),
    .bus   (bus)
  );

  typedef struct {
    int offx;
    int offy;
    int addr;
    int on;
  } vec_t;

  vec_t tbl [10];
  int   total = 0;
  int   bad = 0;
  int   hit_seen = 0;
  int   max_addr = 0;

  // Reference model: slick alive/hit flags, countdown, position and LFSR as plain integers.
  int m_cd, m_ox, m_oy, m_lfsr;
  bit m_live, m_hitd;

  always @(negedge clk) begin
    if (bus.hit === 1'b1) hit_seen++;
    if (!rst) begin
      if (int'(bus.read_address) > max_addr) max_addr = int'(bus.read_address);
      assert (bus.read_address <= 12'd1727)
        else $error("read_address out of range: %0d", bus.read_address);
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, got timeout, expected completion");
    $fatal(1, "timeout");
  end

  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    end
  endtask

  function automatic void model_reset();
    m_cd = 64; m_lfsr = 'hA5; m_ox = 0; m_oy = -36; m_live = 0; m_hitd = 0;
  endfunction

  function automatic bit model_tick(input int sp, input int cx, input int cy);
    bit h = 0;
    int lane;
    if (!m_live) begin
      m_cd--;
      if (m_cd == 0) begin
        lane = m_lfsr % 4;
        if (lane == 3) lane = 0;
        m_ox = 160 + lane * 112 + (112 - 48) / 2;
        m_oy = -36;
        m_cd = 32 + m_lfsr % 128;
        m_live = 1;
        m_hitd = 0;
      end
    end else begin
      m_oy += sp;
      if (m_oy >= 480) m_live = 0;
      else if (!m_hitd && cx < m_ox + 48 && m_ox < cx + 32 && cy < m_oy + 36 && m_oy < cy + 48) begin
        h = 1;
        m_hitd = 1;
      end
    end
    m_lfsr = (m_lfsr >> 1) ^ ((m_lfsr % 2 == 1) ? 'hB8 : 0);
    return h;
  endfunction

  function automatic int model_addr(input int x, input int y, output int on);
    int dx, dy;
    dx = x - m_ox;
    dy = y - m_oy;
    on = (m_live && dx >= 0 && dx < 48 && dy >= 0 && dy < 36) ? 1 : 0;
    return (on != 0) ? dy * 48 + dx : 0;
  endfunction

  task automatic do_tick(input int sp);
    int hb;
    bit eh;
    bus.scroll_speed = 4'(sp);
    hb = hit_seen;
    bus.frame_clk = 1'b1;
    repeat (4) @(negedge clk);
    bus.frame_clk = 1'b0;
    repeat (3) @(negedge clk);
    eh = model_tick(sp, int'(bus.car_x), int'(bus.car_y));
    chk("hit_pulses", hit_seen - hb, int'(eh));
    chk("oil_x", int'(bus.oil_x), m_ox);
    chk("oil_y", int'($signed(bus.oil_y)), m_oy);
  endtask

  task automatic probe(input int x, input int y, input int ea, input int eo);
    int pon;
    void'(model_addr(int'(bus.DrawX), int'(bus.DrawY), pon));
    bus.DrawX = 10'(x);
    bus.DrawY = 10'(y);
    @(negedge clk);
    chk("read_address", int'(bus.read_address), ea);
    chk("oil_on_latency", int'(bus.oil_on), pon);
    @(negedge clk);
    chk("oil_on", int'(bus.oil_on), eo);
  endtask

  task automatic probe_model(input int x, input int y);
    int a, o, xc, yc;
    xc = (x < 0) ? 0 : (x > 1023) ? 1023 : x;
    yc = (y < 0) ? 0 : (y > 1023) ? 1023 : y;
    a = model_addr(xc, yc, o);
    probe(xc, yc, a, o);
  endtask

  task automatic chk_state(input string nm, input oil_state_t exp);
    chk(nm, int'(dut.state_q), int'(exp));
  endtask

  initial begin
    int hb;
    tbl[0] = '{6, 10, 486, 1};
    tbl[1] = '{48, 10, 0, 0};
    tbl[2] = '{47, 35, 1727, 1};
    tbl[3] = '{0, 0, 0, 1};
    tbl[4] = '{-1, 5, 0, 0};
    tbl[5] = '{5, -1, 0, 0};
    tbl[6] = '{0, 36, 0, 0};
    tbl[7] = '{47, 0, 47, 1};
    tbl[8] = '{0, 35, 1680, 1};
    tbl[9] = '{20, 20, 980, 1};

    bus.frame_clk = 1'b0; bus.DrawX = '0; bus.DrawY = '0;
    bus.scroll_speed = '0; bus.car_x = '0; bus.car_y = '0;
    model_reset();
    repeat (3) @(negedge clk);
    chk("reset_read_address", int'(bus.read_address), 0);
    chk("reset_oil_on", int'(bus.oil_on), 0);
    chk("reset_hit", int'(bus.hit), 0);
    chk("reset_oil_x", int'(bus.oil_x), 0);
    chk("reset_oil_y", int'($signed(bus.oil_y)), -36);
    chk_state("reset_state", IDLE);
    rst = 1'b0;
    @(negedge clk);

    // First spawn lands on the 64th tick.
    for (int i = 0; i < 63; i++) do_tick(0);
    chk_state("idle_before_spawn", IDLE);
    do_tick(0);
    chk_state("spawn_state", ACTIVE);

    // Partly above the screen: only rows with dy >= 0 light up.
    for (int i = 0; i < 4; i++) do_tick(4);
    probe(m_ox + 10, 0, 970, 1);
    probe(m_ox + 47, 15, 1727, 1);
    probe(m_ox + 10, 16, 0, 0);
    probe_model(m_ox, 0);

    for (int i = 0; i < 124; i++) do_tick(4);
    chk("oil_y_476", int'($signed(bus.oil_y)), 476);
    chk_state("active_at_476", ACTIVE);
    bus.car_x = 10'(m_ox + 6);
    bus.car_y = 10'd440;
    do_tick(4);
    chk("exit_oil_y", int'($signed(bus.oil_y)), 480);
    chk_state("exit_state", IDLE);

    bus.car_x = '0; bus.car_y = '0;
    for (int g = 0; g < 200 && !m_live; g++) do_tick(4);
    chk_state("respawn_state", ACTIVE);
    for (int i = 0; i < 24; i++) do_tick(4);
    chk("oil_y_60", int'($signed(bus.oil_y)), 60);
    bus.car_x = 10'(m_ox + 6);
    bus.car_y = 10'd120;
    hb = hit_seen;
    for (int i = 0; i < 10; i++) do_tick(4);
    chk("single_hit_pulse", hit_seen - hb, 1);
    chk_state("hit_state", HIT);

    for (int i = 0; i < 10; i++) probe(m_ox + tbl[i].offx, m_oy + tbl[i].offy, tbl[i].addr, tbl[i].on);

    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    bus.car_x = '0; bus.car_y = '0;
    for (int i = 0; i < 64; i++) do_tick(0);
    for (int i = 0; i < 10; i++) do_tick(4);
    probe_model(m_ox + 3, 10);
    chk("pre_reset_oil_on", int'(bus.oil_on), 1);
    #2 rst = 1'b1;
    #1;
    chk("async_reset_oil_on", int'(bus.oil_on), 0);
    chk("async_reset_hit", int'(bus.hit), 0);
    chk("async_reset_oil_y", int'($signed(bus.oil_y)), -36);
    chk("async_reset_read_address", int'(bus.read_address), 0);
    chk_state("async_reset_state", IDLE);
    @(negedge clk);
    rst = 1'b0;
    model_reset();

    for (int t = 0; t < 320; t++) begin
      int sp;
      if ($urandom_range(0, 3) == 0) begin
        bus.car_x = 10'($urandom_range(150, 480));
        bus.car_y = 10'($urandom_range(250, 460));
      end
      sp = ($urandom_range(0, 9) == 0) ? 0 : int'($urandom_range(1, 15));
      do_tick(sp);
      for (int k = 0; k < 2; k++)
        probe_model(m_ox + int'($urandom_range(0, 59)) - 6, m_oy + int'($urandom_range(0, 47)) - 6);
    end

    chk("read_address_max_le_1727", (max_addr <= 1727) ? 1 : 0, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
